lif_layer_net: RTL
==================

// Module: lif_layer_net
// PURPOSE
//  Parametrised two-layer leaky-integrate-and-fire network: N_IN input LIF neurons, each
//  driven by its own I_W-bit current, feed a programmable signed weighted sum into one
//  output LIF neuron. Adds leak shift, threshold, refractory period and run-time weight
//  writes. Sits between the input switches and the spike/state display outputs.
// PARAMETERS
//  N_IN        8    input-layer neuron count (>=2)
//  I_W         8    per-channel input current width, unsigned
//  V_W         8    membrane width, unsigned, saturating
//  W_W         4    weight width, two's complement
//  THRESH      200  input-layer fire threshold (v >= THRESH fires)
//  OUT_THRESH  16   output-neuron fire threshold
//  LEAK_SHIFT  2    leak = v >> LEAK_SHIFT per update
//  REFRAC      2    refractory cycles after a spike (0 = none)
// PORTS
//  clk        in   1            clock
//  rst_n      in   1            synchronous, active-low reset
//  ena        in   1            update enable; low freezes all state
//  current    in   N_IN*I_W     channel i at [i*I_W +: I_W]
//  w_we       in   1            weight write strobe
//  w_addr     in   clog2(N_IN)  weight index; out-of-range writes are ignored
//  w_data     in   W_W          signed weight value
//  l1_spikes  out  N_IN         registered input-layer spikes
//  spike_out  out  1            registered output-neuron spike
//  state_out  out  V_W          output-neuron membrane
// BEHAVIOUR
//  - Reset: every membrane = 0, refractory counters = 0, sum register = 0, l1_spikes = 0,
//    spike_out = 0, state_out = 0, all weights = +1. Reset overrides ena and w_we.
//  - Neuron update on an edge with ena=1:
//    - If refcnt > 0: refcnt--, v = 0, spike = 0, input ignored.
//    - Else: t = v - (v>>LEAK_SHIFT) + in, evaluated at full width, then clamped to [0, 2^V_W-1].
//    - If t >= threshold: spike = 1, v = 0, refcnt = REFRAC. Else: spike = 0, v = t.
//  - Spikes are one-cycle pulses.
//  - ena=0: membranes, counters and the sum register hold; l1_spikes and spike_out are 0.
//    Weight writes still occur.
//  - Sum: sum = signed sum of w[i] over channels with l1_spikes[i]=1.
//    Width W_W+clog2(N_IN)+1; never overflows.
//  - Output neuron: input is the signed sum. A negative t clamps the membrane to 0.
//  - Pipeline: current sampled at edge n -> l1_spikes valid after n; sum register loaded
//    at n+1; spike_out/state_out reflect it after n+2. Fixed 3-edge latency, no stalls
//    while ena=1.
//  - Weight write: w[w_addr] <= w_data at the edge. The new value is used by the sum
//    computed at the next edge. A write at the same edge as the sum load does not affect
//    that sum.
//  - Saturation: a membrane at 2^V_W-1 with further input stays at max until it fires.
//  - state_out = output membrane, which reads 0 on the spike cycle and during refractory.
// STRUCTURE
//  - Package lif_pkg: membrane/weight typedefs, default THRESH/LEAK/REFRAC constants,
//    and a sat_clamp function.
//  - Sub-module lif_neuron, parametrised (IN_W, signed input flag, V_W, THRESH,
//    LEAK_SHIFT, REFRAC). Instantiated N_IN times via generate, plus once for the
//    output neuron.
//  - Top holds the weight register file and the registered adder tree.
// TESTING
//  1. Reset with rst_n=0 and ena=1 -> all outputs 0. After release, reading the
//     weights via the sum path gives +1 each.
//  2. ch0 current=100 held, ena=1 -> v: 100, 175, 232. Spike on the 3rd update,
//     then 2 refractory cycles at v=0; spike period = 5 edges.
//  3. All channels current=255, weights written to 2 -> l1_spikes=0xFF every 3 edges.
//     sum=16, spike_out=1 exactly 2 edges after each l1 burst.
//  4. w[0]=-8, only ch0 driven at 255 -> sum=-8; output membrane stays 0, spike_out
//     never asserts (clamp check).
//  5. Drop ena for 4 cycles mid-integration (ch0 v=175) -> v holds 175, spikes 0.
//     Resume -> next v=232 with a spike.
//  6. Assert rst_n=0 mid-refractory while a weight write is pending -> all state 0,
//     weights +1, the write is dropped.

Source files
------------

// File: rtl/lif_layer_net_pkg.sv
// lif_pkg: shared membrane/weight types, default neuron constants and the membrane clamp
package lif_pkg;
  localparam int DEF_THRESH = 200;
  localparam int DEF_OUT_THRESH = 16;
  localparam int DEF_LEAK_SHIFT = 2;
  localparam int DEF_REFRAC = 2;
  typedef logic [7:0] membrane_t;
  typedef logic signed [3:0] weight_t;
  function automatic int sat_clamp(input int t, input int hi);
    return t < 0 ? 0 : (t > hi ? hi : t);
  endfunction
endpackage

// File: rtl/lif_layer_net_if.sv
// lif_layer_net_if: control, current, weight-write and spike/state signals of the LIF network
interface lif_layer_net_if #(parameter int N_IN = 8, I_W = 8, V_W = 8, W_W = 4);
  localparam int AW = $clog2(N_IN);
  logic ena;
  logic [N_IN*I_W-1:0] current;
  logic w_we;
  logic [AW-1:0] w_addr;
  logic [W_W-1:0] w_data;
  logic [N_IN-1:0] l1_spikes;
  logic spike_out;
  logic [V_W-1:0] state_out;
  modport master (output ena, current, w_we, w_addr, w_data, input l1_spikes, spike_out, state_out);
  modport slave (input ena, current, w_we, w_addr, w_data, output l1_spikes, spike_out, state_out);
endinterface

// File: rtl/lif_layer_net_neuron.sv
// lif_neuron: leaky-integrate-and-fire neuron with saturating membrane and refractory hold
module lif_neuron
  import lif_pkg::*;
#(
  parameter int IN_W = 8,
  parameter bit SIGNED_IN = 1'b0,
  parameter int V_W = 8,
  parameter int THRESH = DEF_THRESH,
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
  parameter int REFRAC = DEF_REFRAC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic [IN_W-1:0] cur,
  output logic spike,
  output logic [V_W-1:0] v
);
  localparam int RW = REFRAC < 1 ? 1 : $clog2(REFRAC + 1);
  logic [RW-1:0] refcnt;
  int in_i, t;
  always_comb begin
    in_i = SIGNED_IN ? int'($signed(cur)) : int'(cur);
    t = sat_clamp(int'(v) - int'(v >> LEAK_SHIFT) + in_i, 2 ** V_W - 1);
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      v <= '0;
      refcnt <= '0;
      spike <= 1'b0;
    end else if (!ena) spike <= 1'b0;
    else if (refcnt != '0) begin
      refcnt <= refcnt - RW'(1);
      v <= '0;
      spike <= 1'b0;
    end else if (t >= THRESH) begin
      refcnt <= RW'(REFRAC);
      v <= '0;
      spike <= 1'b1;
    end else begin
      v <= V_W'(t);
      spike <= 1'b0;
    end
endmodule

// File: rtl/lif_layer_net.sv
// lif_layer_net: input LIF layer feeding a registered signed weighted spike sum into one output LIF neuron
module lif_layer_net
  import lif_pkg::*;
#(
  parameter int N_IN = 8,
  parameter int I_W = 8,
  parameter int V_W = 8,
  parameter int W_W = 4,
  parameter int THRESH = DEF_THRESH,
  parameter int OUT_THRESH = DEF_OUT_THRESH,
  parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
  parameter int REFRAC = DEF_REFRAC
) (
  input logic clk,
  input logic rst_n,
  lif_layer_net_if.slave bus
);
  localparam int SW = W_W + $clog2(N_IN) + 1;
  logic signed [W_W-1:0] w [N_IN];
  logic signed [SW-1:0] sum, sum_n;
  logic [V_W-1:0] l1_v_unused [N_IN];
  for (genvar i = 0; i < N_IN; i++) begin : g_in
    lif_neuron #(.IN_W(I_W), .SIGNED_IN(1'b0), .V_W(V_W), .THRESH(THRESH),
                 .LEAK_SHIFT(LEAK_SHIFT), .REFRAC(REFRAC)) u_n (
      .clk(clk), .rst_n(rst_n), .ena(bus.ena), .cur(bus.current[i*I_W +: I_W]),
      .spike(bus.l1_spikes[i]), .v(l1_v_unused[i]));
  end
  always_comb begin
    sum_n = '0;
    for (int i = 0; i < N_IN; i++) sum_n = bus.l1_spikes[i] ? sum_n + SW'(w[i]) : sum_n;
  end
  always_ff @(posedge clk)
    if (!rst_n) sum <= '0;
    else if (bus.ena) sum <= sum_n;
  // Writes land after this edge's sum load, so a same-edge write only affects the next sum
  always_ff @(posedge clk)
    if (!rst_n) for (int i = 0; i < N_IN; i++) w[i] <= W_W'(1);
    else if (bus.w_we && 32'(bus.w_addr) < N_IN) w[bus.w_addr] <= bus.w_data;
  lif_neuron #(.IN_W(SW), .SIGNED_IN(1'b1), .V_W(V_W), .THRESH(OUT_THRESH),
               .LEAK_SHIFT(LEAK_SHIFT), .REFRAC(REFRAC)) u_out (
    .clk(clk), .rst_n(rst_n), .ena(bus.ena), .cur(sum),
    .spike(bus.spike_out), .v(bus.state_out));
endmodule
